// File: rtl/vm1_irqc.sv
// Interrupt priority controller: latches per-channel requests, arbitrates by
// level (ties to the lowest index) and holds a frozen vector until acknowledged.
module vm1_irqc #(
    parameter int                  NCH       = 8,
    parameter int                  PW        = 3,
    parameter int                  VW        = 16,
    parameter logic [VW-1:0]       VBASE     = 16'o000100,
    parameter int                  VSTEP     = 4,
    parameter logic [NCH*PW-1:0]   PRIO_MAP  = {8{3'd4}},
    parameter logic [NCH-1:0]      EDGE_MASK = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ena,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          mask,
    input  logic [PW-1:0]           cpu_prio,
    input  logic                    iack,
    output logic                    irq,
    output logic [VW-1:0]           vec,
    output logic [$clog2(NCH)-1:0]  chan,
    output logic                    wake,
    output logic                    spur
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t          state_reg, state_next;
    logic [NCH-1:0]  pend_reg, pend_next;
    logic [NCH-1:0]  req_d_reg;
    logic [NCH-1:0]  eligible;
    logic [CW-1:0]   chan_reg;
    logic [VW-1:0]   vec_reg;
    logic            wake_reg, spur_reg;
    logic            rearm_en;
    logic            load_grant;
    logic            any_elig;
    logic [CW-1:0]   win_idx;
    logic [PW-1:0]   win_lvl;
    logic [VW-1:0]   vec_next;

    assign rearm_en = (state_reg == S_REQ) && iack;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign eligible[gi] = pend_reg[gi] & ~mask[gi]
                                & (PRIO_MAP[gi*PW +: PW] > cpu_prio);
            if (EDGE_MASK[gi]) begin : g_edge
                // A fresh edge in the rearm cycle wins so it is never lost.
                assign pend_next[gi] = (req[gi] & ~req_d_reg[gi])
                                     | (pend_reg[gi] & ~(rearm_en && (chan_reg == CW'(gi))));
            end else begin : g_level
                assign pend_next[gi] = req[gi];
            end
        end
    endgenerate

    // Strict '>' keeps the first (lowest-index) channel among equal levels.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        win_lvl  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (eligible[i] && (!any_elig || (PRIO_MAP[i*PW +: PW] > win_lvl))) begin
                any_elig = 1'b1;
                win_idx  = CW'(i);
                win_lvl  = PRIO_MAP[i*PW +: PW];
            end
        end
    end

    assign vec_next = VBASE + VW'(win_idx) * VW'(VSTEP);

    always_comb begin
        state_next = state_reg;
        load_grant = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ena && any_elig) begin
                    state_next = S_REQ;
                    load_grant = 1'b1;
                end
            end
            S_REQ: begin
                if (iack)
                    state_next = S_ACK;
                else if (!eligible[chan_reg])
                    state_next = S_IDLE;
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pend_reg  <= '0;
            req_d_reg <= '0;
            chan_reg  <= '0;
            vec_reg   <= '0;
            wake_reg  <= 1'b0;
            spur_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            req_d_reg <= req;
            wake_reg  <= |(pend_reg & ~mask);
            spur_reg  <= iack && (state_reg != S_REQ);
            if (load_grant) begin
                chan_reg <= win_idx;
                vec_reg  <= vec_next;
            end
        end
    end

    assign irq  = (state_reg == S_REQ);
    assign vec  = vec_reg;
    assign chan = chan_reg;
    assign wake = wake_reg;
    assign spur = spur_reg;
endmodule
